// File: rtl/perif_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a small byte FIFO fed from the shared bus
// and a bit-serial engine with a programmable clocks-per-bit divider.
module perif_uart_tx #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  inout  wire  [63:0] data,
  input  logic        cs,
  input  logic        write_en,
  input  logic        read_en,
  input  logic [1:0]  size,
  output logic        tx,
  output logic        irq
);

  localparam int         AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [4:0]    count_reg;
  logic          overflow_reg, enable_reg;
  logic [15:0]   baud_div_reg, baud_cnt_reg;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt_reg;

  logic [1:0]  reg_sel;
  logic        push_req, push_ok, pop, full, empty, busy, bit_done, ctrl_wr;
  logic [15:0] bit_len_m1;
  logic [63:0] rdata;
  logic        unused_bits;

  assign reg_sel  = address[4:3];
  assign push_req = cs && write_en && (reg_sel == 2'd0);
  assign ctrl_wr  = cs && write_en && (reg_sel == 2'd3);
  assign full     = (count_reg == DEPTH_CNT);
  assign empty    = (count_reg == 5'd0);
  // A pop in the same cycle frees the slot, so a push to a full FIFO is accepted then.
  assign push_ok  = push_req && (!full || pop);
  assign busy     = (state_reg != IDLE);
  assign irq      = empty && !busy;
  assign bit_done = (baud_cnt_reg == 16'd0);
  // Divider of zero behaves as one clock per bit.
  assign bit_len_m1 = (baud_div_reg == 16'd0) ? 16'd0 : baud_div_reg - 16'd1;

  assign unused_bits = &{1'b0, size, address[31:5], address[2:0], data[63:16]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    tx         = 1'b1;
    case (state_reg)
      IDLE: begin
        if (enable_reg && !empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        tx = shift_reg[0];
        if (bit_done && (bit_cnt_reg == 3'd7)) state_next = STOP;
      end
      STOP: begin
        if (bit_done) begin
          if (enable_reg && !empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit timer reloads from the live divider only at bit boundaries.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg    <= 8'd0;
      bit_cnt_reg  <= 3'd0;
      baud_cnt_reg <= 16'd0;
    end else if (pop) begin
      shift_reg    <= fifo_mem[rd_ptr_reg];
      bit_cnt_reg  <= 3'd0;
      baud_cnt_reg <= bit_len_m1;
    end else if (state_reg != IDLE) begin
      if (bit_done) begin
        baud_cnt_reg <= bit_len_m1;
        if (state_reg == DATA) begin
          shift_reg   <= {1'b0, shift_reg[7:1]};
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
      end else begin
        baud_cnt_reg <= baud_cnt_reg - 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= data[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= 5'd0;
      overflow_reg <= 1'b0;
      enable_reg   <= 1'b0;
      baud_div_reg <= DIV_RESET;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push_ok && !pop)      count_reg <= count_reg + 5'd1;
      else if (!push_ok && pop) count_reg <= count_reg - 5'd1;
      if (push_req && full && !pop)  overflow_reg <= 1'b1;
      else if (ctrl_wr && data[1])   overflow_reg <= 1'b0;
      if (ctrl_wr) enable_reg <= data[0];
      if (cs && write_en && (reg_sel == 2'd2)) baud_div_reg <= data[15:0];
    end
  end

  always_comb begin
    rdata = 64'd0;
    case (reg_sel)
      2'd1: begin
        rdata[0]   = full;
        rdata[1]   = empty;
        rdata[2]   = busy;
        rdata[3]   = overflow_reg;
        rdata[8:4] = count_reg;
      end
      2'd2:    rdata[15:0] = baud_div_reg;
      2'd3:    rdata[0]    = enable_reg;
      default: rdata       = 64'd0;
    endcase
  end

  assign data = (cs && read_en && !write_en) ? rdata : {64{1'bz}};

endmodule
